// File: rtl/issue_ctrl.sv
// In-order issue scheduler: scoreboard-based RAW/WAW blocking, in-flight limit,
// redirect flush sequencing and fence drain.
module issue_ctrl #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_dec_req,
  output logic             o_dec_ack,
  input  logic [4:0]       i_dec_rs1,
  input  logic             i_dec_rs1_ren,
  input  logic [4:0]       i_dec_rs2,
  input  logic             i_dec_rs2_ren,
  input  logic [4:0]       i_dec_rd,
  input  logic             i_dec_rd_wen,
  output logic             o_ex_req,
  input  logic             i_ex_ack,
  input  logic             i_ex_redirect,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_wb_rd_wen,
  input  logic             i_fence_req,
  output logic             o_fence_done,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_inflight,
  output logic [31:0]      o_stall_cnt,
  output logic             o_err
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_INFLIGHT);
  localparam logic [FC_W-1:0]  FLUSH_LD  = FC_W'(FLUSH_CYCLES);
  localparam logic [FC_W-1:0]  FLUSH_ONE = FC_W'(1);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [31:0]      sb, sb_nxt;
  logic [CNT_W-1:0] inflight;
  logic [FC_W-1:0]  flush_cnt, flush_cnt_nxt;
  logic [31:0]      stall_cnt;
  logic             err;
  logic             hazard, issue, retire_ok;

  // Hazards see only the registered scoreboard, so a same-cycle retire
  // unblocks a dependent instruction one cycle later.
  always_comb begin
    hazard    = (i_dec_rs1_ren & sb[i_dec_rs1]) |
                (i_dec_rs2_ren & sb[i_dec_rs2]) |
                (i_dec_rd_wen  & sb[i_dec_rd]);
    o_ex_req  = (state == RUN) & i_dec_req & ~hazard & (inflight < MAX_CNT) &
                ~i_ex_redirect & ~i_fence_req;
    issue     = o_ex_req & i_ex_ack;
    retire_ok = i_wb_valid & (inflight != '0);
  end

  // Clear first, then set, so an issue beats a retire on the same index.
  always_comb begin
    sb_nxt = sb;
    if (i_wb_valid && i_wb_rd_wen) sb_nxt[i_wb_rd] = 1'b0;
    if (issue && i_dec_rd_wen)     sb_nxt[i_dec_rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    o_fence_done  = 1'b0;
    case (state)
      RUN: begin
        if (i_ex_redirect) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FLUSH_LD;
        end else if (i_fence_req) begin
          state_nxt = DRAIN;
        end
      end
      FLUSH: begin
        if (i_ex_redirect) begin
          flush_cnt_nxt = FLUSH_LD;
        end else if (flush_cnt <= FLUSH_ONE) begin
          flush_cnt_nxt = '0;
          state_nxt     = RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - FLUSH_ONE;
        end
      end
      DRAIN: begin
        if (i_ex_redirect) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FLUSH_LD;
        end else if (inflight == '0 && !i_wb_valid) begin
          o_fence_done = 1'b1;
          state_nxt    = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      sb        <= '0;
      inflight  <= '0;
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      sb        <= sb_nxt;
      case ({issue, retire_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (i_dec_req && !issue && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (i_wb_valid && inflight == '0) err <= 1'b1;
    end
  end

  assign o_dec_ack   = issue;
  assign o_flush     = (state == FLUSH);
  assign o_inflight  = inflight;
  assign o_stall_cnt = stall_cnt;
  assign o_err       = err;

endmodule
